arb_mux_4x1: RTL and testbench
==============================

// Module: arb_mux_4x1
// PURPOSE
//  Round-robin arbiter that shares one mux_4x1 datapath between four requesters.
//  Registers the owner and drives the mux select lines S1/S0 plus a one-hot grant.
//  Limits bus tenure with an optional hold timeout.
//  Sits beside the mux at the parent level; the mux itself stays combinational.
// PARAMETERS
//  MAX_HOLD  8  max consecutive cycles one owner keeps the grant while others wait; 0 = no limit
//  CNT_W     4  hold-counter width; must satisfy 2**CNT_W >= MAX_HOLD
// PORTS
//  clk     in   1  single clock, rising edge
//  rst_n   in   1  asynchronous, active-low reset
//  req     in   4  request per source; req[i] selects mux input a<i>
//  grant   out  4  one-hot owner, all-zero when idle (registered)
//  S1      out  1  mux select MSB = owner[1] (registered)
//  S0      out  1  mux select LSB = owner[0] (registered)
//  busy    out  1  1 while an owner holds the mux (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; grant=0000; S1=S0=0; busy=0; hold_cnt=0; last=3,
//   so source 0 has highest priority after reset. Reset mid-tenure drops the grant immediately.
//  States: IDLE, OWN.
//  Pick rule (sub-module): first i with req[i]=1, scanning circularly from last+1.
//   The current owner is excluded when switching away from it.
//  IDLE:
//   - req=0000: stay.
//   - Else: on the next edge grant the picked i, set busy=1, S1S0=i, last=i, hold_cnt=0, go OWN.
//   - Latency from req to grant is one edge.
//  OWN (owner o):
//   - req[o]=0: release on the next edge.
//     Other requests pending: grant the next pick directly, with no idle cycle.
//     None pending: go IDLE with grant=0000 and busy=0; S1S0 keeps o.
//   - req[o]=1, MAX_HOLD>0, hold_cnt=MAX_HOLD-1, another req pending: preempt.
//     Grant the next pick on the next edge; hold_cnt=0.
//   - req[o]=1, timeout reached, nothing else pending: keep o; hold_cnt wraps to 0.
//   - Otherwise: keep o; hold_cnt+1.
//  Simultaneous owner drop and timeout: handled as a drop (identical outcome).
//  Switch edge: grant, S1/S0 and last change together.
//   grant is never multi-hot, and never all-zero while busy=1.
//  Invariants:
//   - busy == |grant
//   - when busy=1, {S1,S0} == index of grant
//  Fairness: no source with req held high waits more than 3 tenures.
//  MAX_HOLD=0: the counter is ignored and tenure ends only when the owner drops req.
// STRUCTURE
//  Shared package: state encoding (ST_IDLE, ST_OWN) and source indices SRC0..SRC3 (2-bit).
//  Sub-module rr_pick_4 (combinational):
//   - inputs: req[3:0], last[1:0], excl_en, excl_idx
//   - outputs: pick_vld, pick_idx[1:0]
//  Top: FSM, hold counter and output registers. The parent instantiates mux_4x1 separately,
//   driven by S1/S0.
// TESTING
//  T1 reset: rst_n=0 while req=1111 -> grant=0000, S1S0=00, busy=0; release -> next edge grant=0001.
//  T2 rotation (MAX_HOLD=0): req=1111.
//   - Each owner drops req for 1 cycle after 2 cycles of tenure.
//   - Expected grant order: 0001, 0010, 0100, 1000, 0001.
//   - No idle cycle between owners.
//  T3 timeout (MAX_HOLD=8): req=0011 held.
//   - Expected: 0001 for 8 cycles, then 0010 for 8 cycles, then 0001.
//   - With only req=0001 held, the grant stays 0001 indefinitely.
//  T4 drop/timeout coincide: owner 2 drops req exactly at hold_cnt=7, req[3]=1 -> next edge grant=1000.
//  T5 idle return: single req[1] pulse of 3 cycles -> grant=0010 one edge later.
//   - Back to 0000 one edge after the drop; S1S0 stays 01.
//   - busy falls with grant.
//  T6 async reset mid-tenure: assert rst_n=0 between clock edges while grant=0100.
//   - Outputs clear with no clock edge.
//   - Next grant goes to the lowest pending index.
//  Every test: check the invariants busy==|grant, one-hot grant, and {S1,S0}==index of grant.
//   Connect a mux_4x1 and confirm D equals the owner's input.

Source files
------------

// File: rtl/arb_mux_4x1_pkg.sv
// Shared definitions for the 4-way round-robin arbiter in front of mux_4x1:
// FSM state encoding, source indices and a one-hot helper.
package arb_mux_4x1_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  localparam logic [1:0] SRC0 = 2'd0;
  localparam logic [1:0] SRC1 = 2'd1;
  localparam logic [1:0] SRC2 = 2'd2;
  localparam logic [1:0] SRC3 = 2'd3;

  // Turn a source index into its one-hot grant pattern.
  function automatic logic [3:0] idxToOneHot(input logic [1:0] idx);
    idxToOneHot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/arb_mux_4x1_rr_pick_4.sv
// Combinational round-robin picker: returns the first requesting source found
// when scanning circularly from last+1, optionally skipping one excluded source
// (the current owner when the arbiter is trying to switch away from it).
module rr_pick_4
  import arb_mux_4x1_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       excl_en,
  input  logic [1:0] excl_idx,
  output logic       pick_vld,
  output logic [1:0] pick_idx
);

  logic [3:0] candMask;
  logic [1:0] scanIdx;

  // Scan last+1, last+2, last+3, last (wrapping) and keep the first eligible hit.
  always_comb begin
    candMask = req & ~(excl_en ? idxToOneHot(excl_idx) : 4'b0000);
    pick_vld = 1'b0;
    pick_idx = last;
    scanIdx  = last;
    for (int k = 1; k <= 4; k++) begin
      scanIdx = last + 2'(k);
      if (!pick_vld && candMask[scanIdx]) begin
        pick_vld = 1'b1;
        pick_idx = scanIdx;
      end
    end
  end

endmodule

// File: rtl/arb_mux_4x1.sv
// Round-robin arbiter that owns the select lines of a shared mux_4x1.
// Holds one owner at a time, hands over without idle cycles when others wait,
// and optionally forces a handover after MAX_HOLD cycles of contested tenure.
module arb_mux_4x1
  import arb_mux_4x1_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       S1,
  output logic       S0,
  output logic       busy
);

  localparam bit               HOLD_EN   = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             busy_q, busy_d;

  logic             pickVld;
  logic [1:0]       pickIdx;
  logic             ownerReq;
  logic             timeout;

  // While owning, the owner is excluded so the picker reports "someone else waiting".
  rr_pick_4 u_pick (
    .req      (req),
    .last     (last_q),
    .excl_en  (state_q == ST_OWN),
    .excl_idx (last_q),
    .pick_vld (pickVld),
    .pick_idx (pickIdx)
  );

  assign ownerReq = req[last_q];
  assign timeout  = HOLD_EN && (holdCnt_q == HOLD_LAST);

  // Next-state logic: grant from idle, release/handover on drop, preempt on timeout.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pickVld) begin
          state_d   = ST_OWN;
          grant_d   = idxToOneHot(pickIdx);
          sel_d     = pickIdx;
          last_d    = pickIdx;
          busy_d    = 1'b1;
          holdCnt_d = '0;
        end
      end
      ST_OWN: begin
        if (!ownerReq || timeout) begin
          if (pickVld) begin
            grant_d   = idxToOneHot(pickIdx);
            sel_d     = pickIdx;
            last_d    = pickIdx;
            holdCnt_d = '0;
          end else if (!ownerReq) begin
            state_d   = ST_IDLE;
            grant_d   = 4'b0000;
            busy_d    = 1'b0;
            holdCnt_d = '0;
          end else begin
            holdCnt_d = '0;
          end
        end else begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves last=3 so source 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      holdCnt_q <= '0;
      last_q    <= SRC3;
      sel_q     <= SRC0;
      grant_q   <= 4'b0000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

  assign grant = grant_q;
  assign S1    = sel_q[1];
  assign S0    = sel_q[0];
  assign busy  = busy_q;

endmodule

// File: tb/tb_arb_mux_4x1.sv
// Bench for arb_mux_4x1: one instance with an 8-cycle hold limit (A) and one
// without a limit (B), each tracked by a tenure-based reference model and a
// bench-side mux that must always forward the owner's data.
module tb_arb_mux_4x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] reqA, reqB;
  logic [3:0] grantA, grantB;
  logic       S1A, S0A, busyA, S1B, S0B, busyB;
  logic       checksOn;

  int errCount = 0;
  int checkCount = 0;

  logic [7:0] dataIn [4] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};
  logic [7:0] dA, dB;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  arb_mux_4x1 #(.MAX_HOLD(8), .CNT_W(4)) dutA (
    .clk(clk), .rst_n(rst_n), .req(reqA), .grant(grantA), .S1(S1A), .S0(S0A), .busy(busyA)
  );

  arb_mux_4x1 #(.MAX_HOLD(0), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .req(reqB), .grant(grantB), .S1(S1B), .S0(S0B), .busy(busyB)
  );

  // Behavioural stand-in for the parent's mux_4x1, driven by S1/S0.
  assign dA = dataIn[{S1A, S0A}];
  assign dB = dataIn[{S1B, S0B}];

  // Reference model: owner (-1 when idle), last owner, cycles of current tenure, mux select.
  typedef struct packed {
    int owner;
    int last;
    int tenure;
    int sel;
  } mdl_t;

  localparam mdl_t RESET_M = '{owner: -1, last: 3, tenure: 0, sel: 0};

  mdl_t mA = RESET_M;
  mdl_t mB = RESET_M;

  function automatic int pickRr(input logic [3:0] r, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic mdl_t mdlStep(input mdl_t m, input logic [3:0] r, input int maxHold);
    mdl_t n;
    int cand;
    n = m;
    if (m.owner < 0) begin
      cand = pickRr(r, m.last, -1);
      if (cand >= 0) begin
        n.owner = cand; n.last = cand; n.sel = cand; n.tenure = 1;
      end
    end else begin
      cand = pickRr(r, m.last, m.owner);
      if (!r[m.owner]) begin
        if (cand >= 0) begin
          n.owner = cand; n.last = cand; n.sel = cand; n.tenure = 1;
        end else begin
          n.owner = -1; n.tenure = 0;
        end
      end else if (maxHold > 0 && m.tenure >= maxHold) begin
        if (cand >= 0) begin
          n.owner = cand; n.last = cand; n.sel = cand;
        end
        n.tenure = 1;
      end else begin
        n.tenure = m.tenure + 1;
      end
    end
    return n;
  endfunction

  // Advance both models on every clock edge; async reset clears them at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA <= RESET_M;
      mB <= RESET_M;
    end else begin
      mA <= mdlStep(mA, reqA, 8);
      mB <= mdlStep(mB, reqB, 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareOne(input string tag, input mdl_t m, input logic [3:0] g,
                            input logic s1, input logic s0, input logic b, input logic [7:0] d);
    logic [3:0] expG;
    expG = (m.owner < 0) ? 4'b0000 : (4'b0001 << m.owner);
    checkOutput({tag, ".grant"}, 32'(g), 32'(expG));
    checkOutput({tag, ".sel"}, 32'({s1, s0}), 32'(m.sel));
    checkOutput({tag, ".busy"}, 32'(b), 32'(m.owner >= 0));
    checkOutput({tag, ".busyEqOrGrant"}, 32'(b), 32'(|g));
    checkOutput({tag, ".atMostOneHot"}, 32'($countones(g) <= 1), 32'd1);
    if (b) checkOutput({tag, ".selMatchesGrant"}, 32'(g), 32'(4'b0001 << {s1, s0}));
    if (m.owner >= 0) checkOutput({tag, ".muxD"}, 32'(d), 32'(dataIn[m.owner]));
  endtask

  // Every falling edge, both instances must agree with their models and invariants.
  always @(negedge clk) begin
    if (checksOn) begin
      compareOne("A", mA, grantA, S1A, S0A, busyA, dA);
      compareOne("B", mB, grantB, S1B, S0B, busyB, dB);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    reqA = a;
    reqB = b;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    logic [3:0] dropMask;
    checksOn = 1'b0;
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    #1 rst_n = 1'b0;
    checksOn = 1'b1;

    // T1: reset holds everything idle even with all requests high.
    applyStimulus(4'b1111, 4'b0000);
    tick(2);
    checkOutput("T1.grantInReset", 32'(grantA), 32'h0);
    checkOutput("T1.selInReset", 32'({S1A, S0A}), 32'h0);
    checkOutput("T1.busyInReset", 32'(busyA), 32'h0);
    rst_n = 1'b1;
    tick(1);
    checkOutput("T1.firstGrant", 32'(grantA), 32'h1);
    checkOutput("T1.firstBusy", 32'(busyA), 32'h1);
    applyStimulus(4'b0000, 4'b0000);
    tick(1);
    checkOutput("T1.released", 32'(grantA), 32'h0);

    // T2: unlimited hold, each owner drops for one cycle after two cycles of tenure.
    applyStimulus(4'b0000, 4'b1111);
    tick(1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("T2.order%0d", k), 32'(grantB), 32'(4'b0001 << k));
      checkOutput($sformatf("T2.busy%0d", k), 32'(busyB), 32'h1);
      tick(1);
      dropMask = 4'b1111 & ~(4'b0001 << k);
      applyStimulus(4'b0000, dropMask);
      tick(1);
      applyStimulus(4'b0000, 4'b1111);
    end
    checkOutput("T2.wrapToZero", 32'(grantB), 32'h1);
    applyStimulus(4'b0000, 4'b0000);
    tick(2);

    // T3: hold limit of 8 alternates two contending sources.
    doReset();
    applyStimulus(4'b0011, 4'b0000);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("T3.src0cycle%0d", i), 32'(grantA), 32'h1);
      tick(1);
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("T3.src1cycle%0d", i), 32'(grantA), 32'h2);
      tick(1);
    end
    checkOutput("T3.backToSrc0", 32'(grantA), 32'h1);
    applyStimulus(4'b0001, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("T3.soloHold%0d", i), 32'(grantA), 32'h1);
      tick(1);
    end
    applyStimulus(4'b0000, 4'b0000);
    tick(2);

    // T4: owner 2 drops exactly when its hold limit expires while source 3 asks.
    doReset();
    applyStimulus(4'b0100, 4'b0000);
    tick(1);
    checkOutput("T4.owner2", 32'(grantA), 32'h4);
    tick(7);
    applyStimulus(4'b1000, 4'b0000);
    tick(1);
    checkOutput("T4.handTo3", 32'(grantA), 32'h8);
    checkOutput("T4.sel3", 32'({S1A, S0A}), 32'h3);
    applyStimulus(4'b0000, 4'b0000);
    tick(2);

    // T5: a three-cycle pulse on source 1, then return to idle with S1S0 kept.
    applyStimulus(4'b0010, 4'b0000);
    tick(1);
    checkOutput("T5.grant1", 32'(grantA), 32'h2);
    checkOutput("T5.sel1", 32'({S1A, S0A}), 32'h1);
    checkOutput("T5.busyHigh", 32'(busyA), 32'h1);
    tick(2);
    applyStimulus(4'b0000, 4'b0000);
    tick(1);
    checkOutput("T5.idleGrant", 32'(grantA), 32'h0);
    checkOutput("T5.idleBusy", 32'(busyA), 32'h0);
    checkOutput("T5.selKept", 32'({S1A, S0A}), 32'h1);

    // T6: asynchronous reset between edges while source 2 owns the bus.
    applyStimulus(4'b0100, 4'b0000);
    tick(1);
    checkOutput("T6.owner2", 32'(grantA), 32'h4);
    applyStimulus(4'b0110, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("T6.asyncGrant", 32'(grantA), 32'h0);
    checkOutput("T6.asyncBusy", 32'(busyA), 32'h0);
    checkOutput("T6.asyncSel", 32'({S1A, S0A}), 32'h0);
    tick(1);
    checkOutput("T6.heldInReset", 32'(grantA), 32'h0);
    rst_n = 1'b1;
    tick(1);
    checkOutput("T6.lowestPending", 32'(grantA), 32'h2);
    applyStimulus(4'b0000, 4'b0000);
    tick(2);

    checksOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
